// File: rtl/conv_pe_sched_pkg.sv
// conv_pe_sched_pkg: shared state encoding and geometry defaults for the conv PE scheduler
package conv_pe_sched_pkg;
  localparam int KS_DEF = 5;
  localparam int PE_LAT_DEF = 2;
  localparam int L1_W_DEF = 28;
  localparam int L2_W_DEF = 12;
  localparam int L2_CH_DEF = 3;
  localparam int L1_OW = L1_W_DEF - KS_DEF + 1;
  localparam int L2_OW = L2_W_DEF - KS_DEF + 1;
  localparam int POS_W = 5;
  localparam int CH_W = 2;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_ACCW,
    S_OUT,
    S_DONE
  } state_e;
endpackage

// File: rtl/conv_pos_cnt.sv
// conv_pos_cnt: output-pair position (ox, oy) and input-channel counters with last flags
module conv_pos_cnt
  import conv_pe_sched_pkg::*;
#(
  parameter int L1_OW_P = L1_OW,
  parameter int L2_OW_P = L2_OW,
  parameter int L2_CH = L2_CH_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             init_i,
  input  logic             layer_i,
  input  logic             ch_inc_i,
  input  logic             adv_i,
  output logic [POS_W-1:0] ox_o,
  output logic [POS_W-1:0] oy_o,
  output logic [CH_W-1:0]  ch_o,
  output logic             ch_last_o,
  output logic             pos_last_o
);
  logic [POS_W-1:0] ox_q, ox_d, oy_q, oy_d, ow_m1;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             ox_last;
  assign ow_m1      = layer_i ? POS_W'(L2_OW_P - 1) : POS_W'(L1_OW_P - 1);
  assign ox_last    = ox_q == ow_m1;
  assign ox_o       = ox_q;
  assign oy_o       = oy_q;
  assign ch_o       = ch_q;
  assign ch_last_o  = ch_q == CH_W'(L2_CH - 1);
  assign pos_last_o = ox_last && (oy_q == ow_m1 - POS_W'(1));
  // init zeroes everything; a pair advance walks ox, then steps oy by two rows
  always_comb begin
    ox_d = init_i ? '0 : adv_i ? (ox_last ? '0 : ox_q + POS_W'(1)) : ox_q;
    oy_d = init_i ? '0 : (adv_i && ox_last) ? oy_q + POS_W'(2) : oy_q;
    ch_d = (init_i || adv_i) ? '0 : ch_inc_i ? ch_q + CH_W'(1) : ch_q;
  end
  // position registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ox_q <= '0;
      oy_q <= '0;
      ch_q <= '0;
    end else begin
      ox_q <= ox_d;
      oy_q <= oy_d;
      ch_q <= ch_d;
    end
  end
endmodule

// File: rtl/conv_pe_sched.sv
// conv_pe_sched: sequences line-buffer reads and PE-array control for two conv layers
module conv_pe_sched
  import conv_pe_sched_pkg::*;
#(
  parameter int L1_W = L1_W_DEF,
  parameter int L2_W = L2_W_DEF,
  parameter int L2_CH = L2_CH_DEF,
  parameter int KS = KS_DEF,
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic             layer_i,
  input  logic             out_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             rd_en_o,
  output logic [POS_W-1:0] rd_row_o,
  output logic [POS_W-1:0] rd_col_o,
  output logic [CH_W-1:0]  rd_ch_o,
  output logic             pe_en_o,
  output logic             pe_valid_o,
  output logic             pe_clear_o,
  output logic             layer_change_o,
  output logic             acc_wr_en_o,
  output logic             acc_rd_en_o,
  output logic             pe_valid_out_o,
  output logic             out_valid_o,
  output logic [POS_W-1:0] out_row_o,
  output logic [POS_W-1:0] out_col_o
);
  localparam int CMAX = KS > PE_LAT + 1 ? KS : PE_LAT + 1;
  localparam int CW = CMAX > 2 ? $clog2(CMAX) : 1;
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             layer_q, prev_vld_q, lc_q, pe_valid_q;
  logic             start_acc, cnt_end, ch_inc, adv, ch_last, pos_last;
  logic [POS_W-1:0] ox, oy;
  logic [CH_W-1:0]  ch;
  assign start_acc = (state_q == S_IDLE) && start_i;
  assign cnt_end   = (state_q == S_FEED)  ? cnt_q == CW'(KS - 1) :
                     (state_q == S_DRAIN) ? cnt_q == CW'(PE_LAT) : 1'b0;
  conv_pos_cnt #(
    .L1_OW_P(L1_W - KS + 1),
    .L2_OW_P(L2_W - KS + 1),
    .L2_CH  (L2_CH)
  ) u_pos (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .init_i    (start_acc),
    .layer_i   (layer_q),
    .ch_inc_i  (ch_inc),
    .adv_i     (adv),
    .ox_o      (ox),
    .oy_o      (oy),
    .ch_o      (ch),
    .ch_last_o (ch_last),
    .pos_last_o(pos_last)
  );
  // next state plus channel-step / pair-advance strobes; DRAIN covers the read-latency beat and PE_LAT
  always_comb begin
    state_d = state_q;
    ch_inc  = 1'b0;
    adv     = 1'b0;
    cnt_d   = ((state_q == S_FEED || state_q == S_DRAIN) && !cnt_end) ? cnt_q + CW'(1) : '0;
    case (state_q)
      S_IDLE:  state_d = start_i ? S_CLEAR : S_IDLE;
      S_CLEAR: state_d = S_FEED;
      S_FEED:  state_d = cnt_end ? S_DRAIN : S_FEED;
      S_DRAIN: state_d = cnt_end ? (layer_q ? S_ACCW : S_OUT) : S_DRAIN;
      S_ACCW: begin
        ch_inc  = !ch_last;
        state_d = ch_last ? S_OUT : S_CLEAR;
      end
      S_OUT: begin
        adv     = out_ready_i;
        state_d = out_ready_i ? (pos_last ? S_DONE : S_CLEAR) : S_OUT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // state, beat counter, layer bookkeeping and the read-to-valid delay
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      layer_q    <= 1'b0;
      prev_vld_q <= 1'b0;
      lc_q       <= 1'b0;
      pe_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pe_valid_q <= rd_en_o;
      lc_q       <= start_acc && (!prev_vld_q || layer_i != layer_q);
      if (start_acc) begin
        layer_q    <= layer_i;
        prev_vld_q <= 1'b1;
      end
    end
  end
  assign busy_o         = !(state_q inside {S_IDLE, S_DONE});
  assign pe_en_o        = busy_o;
  assign done_o         = state_q == S_DONE;
  assign rd_en_o        = state_q == S_FEED;
  assign rd_row_o       = rd_en_o ? oy : '0;
  assign rd_col_o       = rd_en_o ? ox + POS_W'(cnt_q) : '0;
  assign rd_ch_o        = rd_en_o ? ch : '0;
  assign pe_valid_o     = pe_valid_q;
  assign pe_clear_o     = state_q == S_CLEAR;
  assign layer_change_o = lc_q;
  assign acc_wr_en_o    = state_q == S_ACCW;
  assign pe_valid_out_o = state_q == S_ACCW;
  assign out_valid_o    = state_q == S_OUT;
  assign acc_rd_en_o    = out_valid_o && layer_q;
  assign out_row_o      = out_valid_o ? oy : '0;
  assign out_col_o      = out_valid_o ? ox : '0;
endmodule

// File: doc/conv_pe_sched.md
CONV_PE_SCHED -- requirements
Module: conv_pe_sched

Interface
REQ-001 Parameters SHALL be: L1_W (default 28), input width/height of layer 1; L2_W (default 12), input width/height of layer 2; L2_CH (default 3), input channels of layer 2; KS (default 5), kernel size; PE_LAT (default 2), cycles from last PE feed beat to a stable PE result.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
clk_i  in  1  sole clock, rising edge
rstn_i  in  1  asynchronous, active-low reset
start_i  in  1  single-cycle start pulse, sampled in IDLE only
layer_i  in  1  0 = layer 1 (single channel), 1 = layer 2 (L2_CH channels), sampled with start_i
out_ready_i  in  1  downstream accepts the current output pair
busy_o  out  1  high from accepted start until DONE exits
done_o  out  1  one-cycle pulse when the last pair is accepted
rd_en_o  out  1  line-buffer read strobe, data returns the next cycle
rd_row_o  out  5  top input row of the 6-row window
rd_col_o  out  5  input column being read
rd_ch_o  out  2  input channel being read
pe_en_o, pe_valid_o, pe_clear_o, layer_change_o, acc_wr_en_o, acc_rd_en_o, pe_valid_out_o  out  1 each  drive PE-array en, valid_i, clear, Layer_change, acc_wr_en, acc_rd_en, valid_o
out_valid_o  out  1  conv output pair (rows oy, oy+1; column ox) is presented
out_row_o, out_col_o  out  5 each  oy and ox of the presented pair
REQ-003 The design SHALL use one clock, clk_i; reset SHALL be rstn_i, asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, CLEAR, FEED, DRAIN, ACCW, OUT, DONE.
REQ-005 IDLE->CLEAR on start_i; the layer is latched, ox=oy=ch=0, busy_o=1.
REQ-006 CLEAR SHALL last 1 cycle with pe_clear_o=1, then go to FEED.
REQ-007 FEED SHALL last KS cycles, k=0..KS-1: rd_en_o=1, rd_row_o=oy, rd_col_o=ox+k, rd_ch_o=ch; pe_valid_o SHALL be rd_en_o delayed by one cycle (aligned with the returned data).
REQ-008 DRAIN SHALL last PE_LAT cycles after the final pe_valid_o beat.
REQ-009 Layer 1: DRAIN->OUT. Layer 2: DRAIN->ACCW for every channel. ACCW asserts acc_wr_en_o=1 and pe_valid_out_o=1 for 1 cycle. From ACCW: if ch<L2_CH-1, ch++ and go to CLEAR; otherwise go to OUT.
REQ-010 In OUT, out_valid_o=1 with out_row_o=oy and out_col_o=ox. acc_rd_en_o=1 in layer 2 and 0 in layer 1. acc_wr_en_o=0.
REQ-011 OUT SHALL hold all outputs stable while out_ready_i=0. The pair is accepted on the first cycle with out_valid_o&out_ready_i=1.
REQ-012 On acceptance, position advances:
- ox++ while ox<OW-1, where OW = W-KS+1 (24 for layer 1, 8 for layer 2);
- else ox=0 and oy+=2;
- ch returns to 0;
- next state is CLEAR, or DONE after the final pair (ox=OW-1, oy=OW-2).
REQ-013 DONE SHALL last 1 cycle with done_o=1, busy_o=0, then go to IDLE.
REQ-014 pe_en_o SHALL be 1 in all states except IDLE and DONE.
REQ-015 layer_change_o SHALL pulse for 1 cycle in the CLEAR cycle immediately after an accepted start whose layer differs from the previous run's layer. The first run after reset SHALL count as a change.
REQ-016 start_i outside IDLE SHALL be ignored. A start_i and a reset in the same cycle: reset SHALL win.
REQ-017 Cycles per pair with out_ready_i held at 1:
- layer 1: 1+KS+1+PE_LAT+1 (10 with defaults; the +1 is the read-latency beat);
- layer 2: L2_CH*(KS+PE_LAT+3)+1 (31 with defaults).
REQ-018 All counters SHALL be unsigned and sized to their maximum values without wrap. rd_col_o SHALL never exceed W-1.

Reset
REQ-019 Reset assertion SHALL force IDLE immediately, including mid-operation.
REQ-020 During reset, every output SHALL be 0, all counters 0, and the latched layer 0 with the "previous layer" marked invalid.
REQ-021 After reset release, no activity SHALL occur until a new start_i.

Structure
REQ-022 A shared package SHALL hold the FSM state enum, the KS/PE_LAT defaults, the output-width constants for both layers, and the L2_CH default.
REQ-023 One sub-module, conv_pos_cnt (ox/oy/ch counters with last-position flags), is natural. Everything else SHALL remain in conv_pe_sched.

Verification
REQ-024 Layer 1, out_ready_i=1: exactly 288 out_valid_o handshakes; first at (0,0), last at (22,23); 10-cycle spacing; done_o follows the last handshake.
REQ-025 Layer 2, out_ready_i=1: 32 handshakes; each pair has 3 acc_wr_en_o pulses with rd_ch_o sequencing 0,1,2, and acc_rd_en_o=1 only in OUT.
REQ-026 Backpressure: out_ready_i=0 for 7 cycles at pair (0,5). out_valid_o and coordinates SHALL hold, no rd_en_o SHALL occur, and the next pair SHALL be (0,6).
REQ-027 Sequential runs: layer 1 then layer 1 then layer 2. layer_change_o SHALL pulse in runs 1 and 3 only. A start_i during busy SHALL have no effect.
REQ-028 Reset mid-FEED of layer 2, ch=1: all outputs SHALL be 0 in the same cycle. After release, a layer 2 start SHALL restart at (0,0), ch=0.
